// File: rtl/fetch_stage_pkg.sv
// Shared constants for the fetch stage: reset and exception PCs, next-PC select
// encodings, exception codes, and the instruction image placed in the ROM.
package fetch_stage_pkg;

   localparam logic [31:0] PC_BEGIN_DFLT   = 32'h0000_3000;
   localparam logic [31:0] EXC_VECTOR_DFLT = 32'h0000_4180;
   localparam int          IMEM_WORDS_DFLT = 4096;

   typedef enum logic [1:0] {
      NPC_PC4 = 2'd0,
      NPC_BR  = 2'd1,
      NPC_J   = 2'd2,
      NPC_JR  = 2'd3
   } npc_sel_e;

   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_NONE = 5'd0;

   // Program image stand-in for code.txt. It is a pure function of the word index,
   // so every ROM word is distinct and the image needs no file at elaboration.
   function automatic logic [31:0] rom_word(input logic [31:0] idx);
      return (idx * 32'h9E37_79B9) ^ 32'h2400_0000;
   endfunction

endpackage

// File: rtl/fetch_stage_imem_rom.sv
// Instruction ROM: WORDS x 32, combinational read.
module imem_rom
   import fetch_stage_pkg::*;
#(
   parameter  int WORDS = IMEM_WORDS_DFLT,
   localparam int AW    = $clog2(WORDS)
) (
   input  logic [AW-1:0] addr,
   output logic [31:0]   rdata
);

   assign rdata = rom_word(32'(addr));

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, next-PC selection with CP0 redirects, fetch address
// checking, and the instruction ROM read.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] PC_BEGIN   = PC_BEGIN_DFLT,
   parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DFLT,
   parameter int          IMEM_WORDS = IMEM_WORDS_DFLT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic [1:0]  npc_sel,
   input  logic [31:0] PC_D,
   input  logic [15:0] imm16_D,
   input  logic [25:0] j_index_D,
   input  logic [31:0] jr_target,
   input  logic        exc_req,
   input  logic        eret_req,
   input  logic [31:0] epc,
   output logic [31:0] IR_F,
   output logic [31:0] PC_F,
   output logic        exc_F,
   output logic [4:0]  exc_code_F,
   output logic [31:0] fetch_cnt
);

   localparam int          AW      = $clog2(IMEM_WORDS);
   localparam logic [31:0] PC_LAST = PC_BEGIN + 32'(4 * IMEM_WORDS) - 32'd4;

   logic [31:0]   pc_q, pc_d;
   logic [31:0]   cnt_q, cnt_d;
   logic [31:0]   pc_d4;
   logic [31:0]   br_off;
   logic          adv;
   logic          addr_err;
   logic [AW-1:0] rom_idx;
   logic [31:0]   rom_data;

   assign pc_d4  = PC_D + 32'd4;
   assign br_off = {{14{imm16_D[15]}}, imm16_D, 2'b00};

   // CP0 redirects bypass the stall; a stall holds both PC and the counter.
   always_comb begin
      pc_d = pc_q;
      adv  = 1'b0;
      if (exc_req) begin
         pc_d = EXC_VECTOR;
         adv  = 1'b1;
      end else if (eret_req) begin
         pc_d = epc;
         adv  = 1'b1;
      end else if (en) begin
         adv = 1'b1;
         case (npc_sel_e'(npc_sel))
            NPC_PC4: pc_d = pc_q + 32'd4;
            NPC_BR:  pc_d = pc_d4 + br_off;
            NPC_J:   pc_d = {pc_d4[31:28], j_index_D, 2'b00};
            NPC_JR:  pc_d = jr_target;
            default: pc_d = pc_q + 32'd4;
         endcase
      end
      cnt_d = adv ? cnt_q + 32'd1 : cnt_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q  <= PC_BEGIN;
         cnt_q <= '0;
      end else begin
         pc_q  <= pc_d;
         cnt_q <= cnt_d;
      end
   end

   assign addr_err = (pc_q[1:0] != 2'b00) || (pc_q < PC_BEGIN) || (pc_q > PC_LAST);
   // A bad PC never reaches the ROM address; word 0 is read and then discarded.
   assign rom_idx  = addr_err ? '0 : AW'((pc_q - PC_BEGIN) >> 2);

   imem_rom #(.WORDS(IMEM_WORDS)) u_rom (
      .addr  (rom_idx),
      .rdata (rom_data)
   );

   assign PC_F       = pc_q;
   assign fetch_cnt  = cnt_q;
   assign IR_F       = addr_err ? 32'h0 : rom_data;
   assign exc_F      = addr_err;
   assign exc_code_F = addr_err ? EXC_ADEL : EXC_NONE;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed sequences plus randomized traffic
// against a PC/counter reference model.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset, en, exc_req, eret_req;
   logic [1:0]  npc_sel;
   logic [31:0] PC_D, jr_target, epc;
   logic [15:0] imm16_D;
   logic [25:0] j_index_D;
   logic [31:0] IR_F, PC_F, fetch_cnt;
   logic        exc_F;
   logic [4:0]  exc_code_F;

   int n_chk  = 0;
   int n_pass = 0;

   logic [31:0] m_pc, m_cnt;

   always #5 clk = ~clk;

   fetch_stage dut (
      .clk(clk), .reset(reset), .en(en), .npc_sel(npc_sel), .PC_D(PC_D),
      .imm16_D(imm16_D), .j_index_D(j_index_D), .jr_target(jr_target),
      .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
      .IR_F(IR_F), .PC_F(PC_F), .exc_F(exc_F), .exc_code_F(exc_code_F),
      .fetch_cnt(fetch_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic bad_pc(input logic [31:0] pc);
      return pc[1:0] != 0 || pc < 32'h3000 || pc > 32'h3000 + 32'h4000 - 32'd4;
   endfunction

   function automatic logic [31:0] exp_ir(input logic [31:0] pc);
      if (bad_pc(pc)) return 32'h0;
      return (((pc - 32'h3000) / 4) * 32'h9E37_79B9) ^ 32'h2400_0000;
   endfunction

   // Model the next PC from the inputs currently applied, clock once, then compare.
   task automatic step(input string tag);
      logic [31:0] nxt, sext;
      logic        upd;
      nxt  = m_pc;
      upd  = 1'b0;
      sext = 32'(signed'(imm16_D)) * 4;
      if (reset) begin
         nxt = 32'h3000;
      end else if (exc_req) begin
         nxt = 32'h4180; upd = 1'b1;
      end else if (eret_req) begin
         nxt = epc; upd = 1'b1;
      end else if (en) begin
         upd = 1'b1;
         if (npc_sel == 0)      nxt = m_pc + 4;
         else if (npc_sel == 1) nxt = PC_D + 4 + sext;
         else if (npc_sel == 2) nxt = ((PC_D + 4) & 32'hF000_0000) | ({6'd0, j_index_D} * 4);
         else                   nxt = jr_target;
      end
      m_cnt = reset ? 32'd0 : (upd ? m_cnt + 1 : m_cnt);
      m_pc  = nxt;
      @(posedge clk);
      #1;
      chk({tag, ".pc"},   PC_F, m_pc);
      chk({tag, ".cnt"},  fetch_cnt, m_cnt);
      chk({tag, ".ir"},   IR_F, exp_ir(m_pc));
      chk({tag, ".exc"},  {31'd0, exc_F}, {31'd0, bad_pc(m_pc)});
      chk({tag, ".code"}, {27'd0, exc_code_F}, bad_pc(m_pc) ? 32'd4 : 32'd0);
   endtask

   task automatic idle_inputs();
      en = 1'b1; npc_sel = 2'd0; exc_req = 1'b0; eret_req = 1'b0;
      PC_D = 32'h3000; imm16_D = '0; j_index_D = '0; jr_target = 32'h3000; epc = 32'h3000;
   endtask

   initial begin
      m_pc = 32'h3000; m_cnt = 0;
      idle_inputs();
      reset = 1'b1;
      en = 1'b0; exc_req = 1'b1; eret_req = 1'b1; npc_sel = 2'd3;
      step("rst0");
      step("rst1");
      reset = 1'b0;
      idle_inputs();
      step("seq1");
      step("seq2");
      en = 1'b0; npc_sel = 2'd1; PC_D = 32'h3100; imm16_D = 16'h0040;
      repeat (3) step("stall");
      en = 1'b1; npc_sel = 2'd1; PC_D = 32'h3010; imm16_D = 16'hFFFE;
      step("branch");
      chk("branch.abs", PC_F, 32'h300C);
      npc_sel = 2'd2; j_index_D = 26'hC20;
      step("jump");
      chk("jump.abs", PC_F, 32'h3080);
      npc_sel = 2'd3; jr_target = 32'h3002;
      step("jr_misal");
      jr_target = 32'h2FFC;
      step("jr_low");
      jr_target = 32'h7000;
      step("jr_high");
      jr_target = 32'h6FFC;
      step("jr_last");
      en = 1'b0; exc_req = 1'b1; eret_req = 1'b1;
      step("exc");
      chk("exc.abs", PC_F, 32'h4180);
      exc_req = 1'b0; epc = 32'h3020;
      step("eret");
      chk("eret.abs", PC_F, 32'h3020);
      idle_inputs();

      @(negedge clk);
      force dut.cnt_q = 32'hFFFF_FFFF;
      #1 release dut.cnt_q;
      m_cnt = 32'hFFFF_FFFF;
      step("wrap");
      chk("wrap.abs", fetch_cnt, 32'h0);

      // reset taken during a pending redirect must discard it
      exc_req = 1'b1; reset = 1'b1;
      step("rst_redir");
      reset = 1'b0; idle_inputs();

      for (int i = 0; i < 3000; i++) begin
         reset     = ($urandom_range(0, 63) == 0);
         en        = ($urandom_range(0, 3) != 0);
         exc_req   = ($urandom_range(0, 15) == 0);
         eret_req  = ($urandom_range(0, 15) == 0);
         npc_sel   = 2'($urandom_range(0, 3));
         PC_D      = 32'h3000 + ($urandom_range(0, 32'h3FFF) & ~32'd3);
         imm16_D   = 16'($urandom);
         j_index_D = ($urandom_range(0, 1) == 0) ? 26'($urandom_range(32'hC00, 32'h1BFF)) : 26'($urandom);
         jr_target = ($urandom_range(0, 3) == 0) ? $urandom : 32'h3000 + 32'($urandom_range(0, 32'h4000));
         epc       = ($urandom_range(0, 3) == 0) ? $urandom : 32'h3000 + ($urandom_range(0, 32'h3FFF) & ~32'd3);
         step("rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter PC_BEGIN, default 32'h0000_3000, the reset and first-fetch PC.
REQ-002 The block SHALL have parameter EXC_VECTOR, default 32'h0000_4180, the exception entry PC.
REQ-003 The block SHALL have parameter IMEM_WORDS, default 4096, the instruction ROM depth in words.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 en  input  1  advance enable from hazard unit; 0 = stall fetch.
REQ-007 npc_sel  input  2  next-PC select from decode: 0 PC+4, 1 branch, 2 j/jal, 3 jr.
REQ-008 PC_D  input  32  PC of the instruction in decode.
REQ-009 imm16_D  input  16  branch offset field of the decode instruction.
REQ-010 j_index_D  input  26  jump index field of the decode instruction.
REQ-011 jr_target  input  32  forwarded rs value for jr/jalr.
REQ-012 exc_req  input  1  CP0 exception redirect request.
REQ-013 eret_req  input  1  CP0 eret redirect request.
REQ-014 epc  input  32  return address for eret.
REQ-015 IR_F  output  32  fetched instruction, to IF/ID register.
REQ-016 PC_F  output  32  current fetch PC, to IF/ID register.
REQ-017 exc_F  output  1  fetch address error flag.
REQ-018 exc_code_F  output  5  exception code; 5'd4 (AdEL) when exc_F, else 0.
REQ-019 fetch_cnt  output  32  count of fetch advances since reset.

Function
REQ-020 PC_F SHALL be the PC register; IR_F, exc_F, exc_code_F SHALL be combinational from PC_F (zero-latency ROM read).
REQ-021 Next PC priority SHALL be: reset > exc_req > eret_req > en=0 (hold) > npc_sel.
REQ-022 exc_req SHALL load EXC_VECTOR and eret_req SHALL load epc regardless of en; exc_req wins when both asserted.
REQ-023 en=0 with no CP0 request SHALL hold PC_F and fetch_cnt unchanged, ignoring npc_sel.
REQ-024 npc_sel=0 SHALL load PC_F+4 (32-bit wrap-around).
REQ-025 npc_sel=1 SHALL load PC_D+4+(sign-extended imm16_D shifted left 2), 32-bit modulo.
REQ-026 npc_sel=2 SHALL load {(PC_D+4)[31:28], j_index_D, 2'b00}.
REQ-027 npc_sel=3 SHALL load jr_target unmodified.
REQ-028 Address error SHALL be flagged when PC_F[1:0]!=0 or PC_F outside [PC_BEGIN, PC_BEGIN+4*IMEM_WORDS-4].
REQ-029 On address error IR_F SHALL be 32'h0 (nop), exc_F=1, exc_code_F=5'd4; the ROM SHALL NOT be indexed by the bad address.
REQ-030 The ROM word index SHALL be (PC_F-PC_BEGIN)[13:2].
REQ-031 fetch_cnt SHALL increment by 1 on every edge where PC_F updates without reset, wrapping 32'hFFFF_FFFF to 0.

Reset
REQ-032 Reset SHALL set PC_F=PC_BEGIN and fetch_cnt=0; IR_F then equals ROM word 0, exc_F=0.
REQ-033 Reset SHALL override en, exc_req, eret_req and npc_sel in the same cycle.
REQ-034 Reset asserted mid-stall or mid-redirect SHALL discard the pending redirect.

Structure
REQ-035 PC_BEGIN, EXC_VECTOR, NPC_* encodings and EXC_ADEL SHALL live in the shared macro/package file.
REQ-036 The ROM SHALL be a sub-module imem_rom (IMEM_WORDS x 32, combinational read, initialised from code.txt).
REQ-037 Next-PC muxing and address checking SHALL be in fetch_stage itself.

Verification
REQ-038 Reset 2 cycles, then en=1, npc_sel=0 -> PC_F 0x3000, then 0x3004, 0x3008; fetch_cnt 0,1,2.
REQ-039 At PC_F=0x3008, en=0 for 3 cycles with npc_sel=1 -> PC_F stays 0x3008, fetch_cnt unchanged.
REQ-040 npc_sel=1, PC_D=0x3010, imm16_D=0xFFFE -> PC_F=0x300C next cycle; npc_sel=2, PC_D=0x3010, j_index_D=0xC20 -> PC_F=0x3080.
REQ-041 npc_sel=3, jr_target=0x3002 -> PC_F=0x3002, IR_F=0, exc_F=1, exc_code_F=4; jr_target=0x2FFC -> same flags.
REQ-042 exc_req=1, eret_req=1, en=0 -> PC_F=0x4180; then eret_req=1, epc=0x3020 -> PC_F=0x3020.
REQ-043 fetch_cnt forced to 0xFFFF_FFFF (via advance sequence or force), one advance -> fetch_cnt=0.
